// File: rtl/popcount10_err_monitor.sv
`default_nettype none
// ============================================================================
// popcount10_err_monitor : exhaustive 10-bit error sweep of an approximate popcount.
// Optional signed bias accumulator enabled by POPCOUNT10_ERRMON_BIAS_EN.  Rev 1.0
// ============================================================================
module popcount10_err_monitor #(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  pc_in,
   output logic [9:0]  stim_out,
   output logic        busy,
   output logic        done,
   output logic [13:0] err_sum,
   output logic [3:0]  wce,
   output logic [10:0] err_cnt
`ifdef POPCOUNT10_ERRMON_BIAS_EN
   ,
   output logic signed [14:0] bias_sum
`endif
);

   localparam logic [7:0] c_settle_last = 8'(SETTLE);
   localparam logic [9:0] c_last_vec    = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_settle_cnt;
   logic       w_accept;
   logic       w_sample;
   logic [3:0] w_exact;
   logic [4:0] w_diff;
   logic [4:0] w_neg_diff;
   logic [3:0] w_abs_err;

   always_comb begin
      w_exact = 4'd0;
      for (int i = 0; i < 10; i++) begin
         w_exact = w_exact + {3'd0, stim_out[i]};
      end
   end

   // Signed pc_in - exact in 5 bits; magnitude never exceeds 15.
   assign w_diff     = {1'b0, pc_in} - {1'b0, w_exact};
   assign w_neg_diff = 5'd0 - w_diff;
   assign w_abs_err  = w_diff[4] ? w_neg_diff[3:0] : w_diff[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_sample     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_settle_cnt == c_settle_last) begin
               w_sample = 1'b1;
               if (stim_out == c_last_vec) begin
                  w_state_next = DONE;
               end
            end
         end
         DONE: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_out     <= 10'd0;
         r_settle_cnt <= 8'd0;
         err_sum      <= 14'd0;
         wce          <= 4'd0;
         err_cnt      <= 11'd0;
      end else if (w_accept) begin
         stim_out     <= 10'd0;
         r_settle_cnt <= 8'd0;
         err_sum      <= 14'd0;
         wce          <= 4'd0;
         err_cnt      <= 11'd0;
      end else if (r_state == RUN) begin
         if (w_sample) begin
            r_settle_cnt <= 8'd0;
            err_sum      <= err_sum + {10'd0, w_abs_err};
            wce          <= (w_abs_err > wce) ? w_abs_err : wce;
            err_cnt      <= err_cnt + {10'd0, |w_abs_err};
            // The final vector is left on stim_out for inspection in IDLE.
            if (stim_out != c_last_vec) begin
               stim_out <= stim_out + 10'd1;
            end
         end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
         end
      end
   end

`ifdef POPCOUNT10_ERRMON_BIAS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_sum <= 15'sd0;
      end else if (w_accept) begin
         bias_sum <= 15'sd0;
      end else if (w_sample) begin
         bias_sum <= bias_sum + $signed({{10{w_diff[4]}}, w_diff});
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_popcount10_err_monitor.sv
`default_nettype none
// ============================================================================
// tb_popcount10_err_monitor : scoreboard bench for popcount10_err_monitor.  Rev 1.0
// ============================================================================
module tb_popcount10_err_monitor;

   typedef struct {
      int sum;
      int wce;
      int cnt;
      int bias;
      int busy_cycles;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        start [2];
   logic        busy  [2];
   logic        done  [2];
   logic [3:0]  pc_in [2];
   logic [3:0]  wce   [2];
   logic [9:0]  stim  [2];
   logic [13:0] err_sum [2];
   logic [10:0] err_cnt [2];
   int          mode  [2];
`ifdef POPCOUNT10_ERRMON_BIAS_EN
   logic signed [14:0] bias [2];
`endif

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   errors = 0;
   int   busy_cnt [2] = '{0, 0};
   int   done_cnt [2] = '{0, 0};

   popcount10_err_monitor #(.SETTLE(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .pc_in(pc_in[0]),
      .stim_out(stim[0]), .busy(busy[0]), .done(done[0]),
      .err_sum(err_sum[0]), .wce(wce[0]), .err_cnt(err_cnt[0])
`ifdef POPCOUNT10_ERRMON_BIAS_EN
      , .bias_sum(bias[0])
`endif
   );

   popcount10_err_monitor #(.SETTLE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .pc_in(pc_in[1]),
      .stim_out(stim[1]), .busy(busy[1]), .done(done[1]),
      .err_sum(err_sum[1]), .wce(wce[1]), .err_cnt(err_cnt[1])
`ifdef POPCOUNT10_ERRMON_BIAS_EN
      , .bias_sum(bias[1])
`endif
   );

   // Models of the popcount under test: 0 exact, 1 stuck-zero, 2 off-by-one, 3 constant 15.
   function automatic logic [3:0] model(input int m, input logic [9:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 10; i++) c = c + {3'd0, v[i]};
      case (m)
         0:       return c;
         1:       return 4'd0;
         2:       return c + 4'd1;
         default: return 4'd15;
      endcase
   endfunction

   assign pc_in[0] = model(mode[0], stim[0]);
   assign pc_in[1] = model(mode[1], stim[1]);

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n[k]) begin
            busy_cnt[k] = 0;
         end else begin
            if (busy[k]) begin
               if (busy_cnt[k] == 0) check($sformatf("dut%0d first_vector", k), int'(stim[k]), 0);
               busy_cnt[k]++;
            end
            if (done[k]) begin
               done_cnt[k]++;
               if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL dut%0d unexpected_done: got pulse expected none", k);
               end else begin
                  if (k == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  check($sformatf("dut%0d busy_cycles", k), busy_cnt[k], e.busy_cycles);
                  check($sformatf("dut%0d err_sum", k), int'(err_sum[k]), e.sum);
                  check($sformatf("dut%0d wce", k), int'(wce[k]), e.wce);
                  check($sformatf("dut%0d err_cnt", k), int'(err_cnt[k]), e.cnt);
`ifdef POPCOUNT10_ERRMON_BIAS_EN
                  check($sformatf("dut%0d bias_sum", k), int'(bias[k]), e.bias);
`endif
               end
               busy_cnt[k] = 0;
            end
         end
      end
   end

   task automatic push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic pulse_start(input int k);
      start[k] = 1'b1;
      @(posedge clk);
      #1 start[k] = 1'b0;
   endtask

   task automatic wait_drain(input int k, input int budget);
      int n;
      n = 0;
      while (((k == 0) ? q0.size() : q1.size()) != 0 || busy[k] || done[k]) begin
         @(posedge clk);
         #1;
         n++;
         if (n > budget) begin
            checks++;
            errors++;
            $display("FAIL dut%0d timeout: got no done within %0d cycles expected done", k, budget);
            if (k == 0) q0.delete();
            else        q1.delete();
            return;
         end
      end
   endtask

   task automatic run_sweep(input int k, input int m, input exp_t e);
      mode[k] = m;
      push(k, e);
      pulse_start(k);
      wait_drain(k, 5000);
   endtask

   task automatic check_zero(input int k, input string tag);
      check($sformatf("dut%0d %s stim_out", k, tag), int'(stim[k]), 0);
      check($sformatf("dut%0d %s busy", k, tag), int'(busy[k]), 0);
      check($sformatf("dut%0d %s done", k, tag), int'(done[k]), 0);
      check($sformatf("dut%0d %s err_sum", k, tag), int'(err_sum[k]), 0);
      check($sformatf("dut%0d %s wce", k, tag), int'(wce[k]), 0);
      check($sformatf("dut%0d %s err_cnt", k, tag), int'(err_cnt[k]), 0);
`ifdef POPCOUNT10_ERRMON_BIAS_EN
      check($sformatf("dut%0d %s bias_sum", k, tag), int'(bias[k]), 0);
`endif
   endtask

   initial begin
      int n;
      rst_n = '{1'b0, 1'b0};
      start = '{1'b0, 1'b0};
      mode  = '{0, 0};
      repeat (3) @(posedge clk);
      #1;
      check_zero(0, "reset");
      check_zero(1, "reset");
      rst_n = '{1'b1, 1'b1};
      @(posedge clk);
      #1;

      run_sweep(0, 0, '{0, 0, 0, 0, 3072});
      run_sweep(0, 1, '{5120, 10, 1023, -5120, 3072});

      // Off-by-one model with stray start pulses mid-sweep.
      mode[0] = 2;
      push(0, '{1024, 1, 1024, 1024, 3072});
      pulse_start(0);
      repeat (9) @(posedge clk);
      #1 pulse_start(0);
      repeat (1988) @(posedge clk);
      #1 pulse_start(0);
      wait_drain(0, 5000);

      // Constant-15 model, SETTLE=0, start held through DONE for back-to-back sweeps.
      mode[1] = 3;
      push(1, '{10240, 15, 1024, 10240, 1024});
      push(1, '{10240, 15, 1024, 10240, 1024});
      start[1] = 1'b1;
      n = 0;
      while (done_cnt[1] < 1 && n < 3000) begin
         @(posedge clk);
         #1 n++;
      end
      n = 0;
      while (!busy[1] && n < 10) begin
         @(posedge clk);
         #1 n++;
      end
      check("dut1 restart_from_held_start", int'(busy[1]), 1);
      start[1] = 1'b0;
      wait_drain(1, 5000);
      repeat (5) @(posedge clk);
      #1;
      check("dut1 idle_hold stim_out", int'(stim[1]), 1023);
      check("dut1 idle_hold err_sum", int'(err_sum[1]), 10240);
      check("dut1 idle_hold wce", int'(wce[1]), 15);
      check("dut1 idle_hold err_cnt", int'(err_cnt[1]), 1024);
      check("dut1 idle_hold busy", int'(busy[1]), 0);

      // Asynchronous reset ~500 cycles into a stuck-zero sweep, then a clean restart.
      mode[0] = 1;
      pulse_start(0);
      repeat (499) @(posedge clk);
      #3 rst_n[0] = 1'b0;
      #1 check_zero(0, "abort");
      repeat (2) @(posedge clk);
      #1 rst_n[0] = 1'b1;
      @(posedge clk);
      #1;
      run_sweep(0, 0, '{0, 0, 0, 0, 3072});

      check("dut0 done_pulses", done_cnt[0], 4);
      check("dut1 done_pulses", done_cnt[1], 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
